// File: rtl/sha256_block_seq.sv
// rtl/sha256_block_seq.sv - SHA-256 block sequencer: word load, message schedule, round/update control
module sha256_block_seq #(
    parameter int BLOCK_CNT_W = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cfg_init,
    input  logic                   cfg_abort,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [31:0]            msg_data,
    output logic                   core_init,
    output logic                   core_round_en,
    output logic [5:0]             core_round_idx,
    output logic [31:0]            core_w,
    output logic                   core_update,
    output logic                   busy,
    output logic                   done,
    output logic [BLOCK_CNT_W-1:0] block_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROUND  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [3:0]               word_cnt_q;
    logic [5:0]               round_cnt_q;
    logic                     init_pending_q;
    logic [31:0]              window_q [16];
    logic [BLOCK_CNT_W-1:0]   block_cnt_q;
    logic                     msg_ready_q;
    logic                     core_init_q;
    logic                     done_q;

    logic                     accept;
    logic                     in_round;
    logic [31:0]              w_next;

    // Small sigma functions of the SHA-256 message schedule
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Abort wins over any handshake in the same cycle, so the word is simply dropped
    assign accept   = msg_valid && msg_ready_q && !cfg_abort;
    assign in_round = (state_q == ST_ROUND);

    // Next schedule word; window[0] is W_t, so window[15] receives W_(t+16)
    assign w_next = sigma1(window_q[14]) + window_q[9] + sigma0(window_q[1]) + window_q[0];

    // Next-state selection: abort forces IDLE, otherwise load/round/update sequencing
    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (accept) state_d = ST_LOAD;
                ST_LOAD:   if (accept && (word_cnt_q == 4'd15)) state_d = ST_ROUND;
                ST_ROUND:  if (round_cnt_q == 6'd63) state_d = ST_UPDATE;
                ST_UPDATE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer state, counters and registered status/control pulses
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= 4'd0;
            round_cnt_q    <= 6'd0;
            init_pending_q <= 1'b0;
            block_cnt_q    <= '0;
            msg_ready_q    <= 1'b0;
            core_init_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
            core_init_q <= 1'b0;
            done_q      <= 1'b0;

            // An init request outside IDLE is parked until the sequencer is idle again
            if (state_q == ST_IDLE) begin
                if (cfg_init || init_pending_q) begin
                    core_init_q    <= 1'b1;
                    init_pending_q <= 1'b0;
                    block_cnt_q    <= '0;
                end
            end else if (cfg_init) begin
                init_pending_q <= 1'b1;
            end

            if (cfg_abort) begin
                word_cnt_q  <= 4'd0;
                round_cnt_q <= 6'd0;
            end else begin
                if (accept) begin
                    word_cnt_q <= word_cnt_q + 4'd1;
                end
                if (state_q == ST_ROUND) begin
                    round_cnt_q <= round_cnt_q + 6'd1;
                end
                // Completion: done and the count bump land on the first IDLE cycle
                if (state_q == ST_UPDATE) begin
                    done_q      <= 1'b1;
                    block_cnt_q <= block_cnt_q + BLOCK_CNT_W'(1);
                end
            end
        end
    end

    // Message window: written by index while loading, shifted down while rounding
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 16; i++) begin
                window_q[i] <= 32'd0;
            end
        end else if (accept) begin
            window_q[word_cnt_q] <= msg_data;
        end else if (in_round) begin
            for (int i = 0; i < 15; i++) begin
                window_q[i] <= window_q[i+1];
            end
            window_q[15] <= w_next;
        end
    end

    assign msg_ready      = msg_ready_q;
    assign core_init      = core_init_q;
    assign core_round_en  = in_round;
    assign core_round_idx = in_round ? round_cnt_q : 6'd0;
    assign core_w         = in_round ? window_q[0] : 32'd0;
    assign core_update    = (state_q == ST_UPDATE);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign block_cnt      = block_cnt_q;

endmodule

// File: doc/sha256_block_seq.md
SHA256_BLOCK_SEQ -- requirements
Module: sha256_block_seq

Interface
REQ-001 The module SHALL have parameter BLOCK_CNT_W, default 16, which sets the width of the completed-block counter.
REQ-002 The module SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The module SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port cfg_init, input, 1 bit: pulse requesting that the core hash state reload the IV before the next block.
REQ-005 The module SHALL have port cfg_abort, input, 1 bit: pulse that discards the block in progress.
REQ-006 The module SHALL have ports msg_valid (input, 1), msg_ready (output, 1) and msg_data (input, 32): the message word stream, one 32-bit word per handshake, W0 first.
REQ-007 The module SHALL have ports core_init (output, 1), core_round_en (output, 1), core_round_idx (output, 6), core_w (output, 32) and core_update (output, 1): the compression-core control.
REQ-008 The module SHALL have ports busy (output, 1), done (output, 1) and block_cnt (output, BLOCK_CNT_W): status.

Function
REQ-009 The module SHALL implement states IDLE, LOAD, ROUND and UPDATE.
REQ-010 msg_ready SHALL be 1 in IDLE and LOAD and 0 in ROUND and UPDATE; a word is accepted when msg_valid and msg_ready are both 1.
REQ-011 An accepted word SHALL be written to a 16-entry window at index word_cnt (4 bits), and word_cnt SHALL then increment.
- IDLE goes to LOAD on the first accept.
- LOAD goes to ROUND on the cycle after the 16th accept (word_cnt wraps 15->0).
REQ-012 ROUND SHALL last exactly 64 cycles, with core_round_en=1 and core_round_idx = round_cnt running 0..63.
REQ-013 core_w SHALL equal window[0] in every ROUND cycle, so that it carries W_t.
- Each ROUND cycle the window shifts down by one.
- window[15] takes sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], mod 2^32.
- sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-014 After round 63, UPDATE SHALL last one cycle with core_update=1, then return to IDLE.
- done=1 for exactly one cycle, on the first IDLE cycle.
- block_cnt increments on that cycle and wraps from all-ones to 0.
REQ-015 If the 16th word is accepted in cycle N, then:
- core_round_en SHALL be 1 in cycles N+1..N+64;
- core_update SHALL be 1 in cycle N+65;
- done SHALL be 1 and msg_ready SHALL be 1 in cycle N+66.
REQ-016 core_init SHALL be a registered one-cycle pulse issued one cycle after cfg_init is sampled in IDLE.
- cfg_init sampled in any other state sets init_pending, and core_init is issued on the first IDLE cycle after that.
- block_cnt SHALL clear to 0 in the same cycle as core_init.
REQ-017 cfg_init and a word accept in the same IDLE cycle SHALL both take effect: core_init on the next cycle, and the word stored as W0.
REQ-018 cfg_abort SHALL move the block to IDLE on the next cycle from any state.
- word_cnt and round_cnt clear to 0.
- core_update and done are not asserted, and block_cnt is unchanged.
- init_pending is kept.
REQ-019 cfg_abort SHALL take priority over a word accept or a state advance in the same cycle.
REQ-020 busy SHALL be 1 whenever the state is not IDLE.
REQ-021 core_round_idx and core_w SHALL be 0 when core_round_en is 0.
REQ-022 msg_data SHALL be ignored when no handshake occurs.

Reset
REQ-023 While areset=1, the block SHALL hold the following values, taking effect immediately and not waiting for a clock edge:
- state IDLE;
- word_cnt=0, round_cnt=0, init_pending=0;
- window all zero;
- block_cnt=0;
- msg_ready=0, core_init=0, core_round_en=0, core_round_idx=0, core_w=0, core_update=0, busy=0, done=0.
REQ-024 msg_ready SHALL return to 1 on the first clock edge after areset deasserts.
REQ-025 areset asserted mid-ROUND SHALL abandon the block with no core_update.

Verification
REQ-026 Scenario "abc" block:
- Stimulus: cfg_init, then W0=0x61626380, W1..W14=0, W15=0x00000018, with msg_valid held high.
- Response: core_init pulses once; ROUND sees core_w=0x61626380 at idx 0, 0x00000018 at idx 15, 0x61626380 at idx 16, 0x000F0000 at idx 17; core_update 65 cycles after the 16th accept; done pulses the cycle after; block_cnt=1.
REQ-027 Scenario back-to-back blocks:
- Stimulus: 32 words of 0xADADADAD with no cfg_init between blocks.
- Response: core_init is not reissued; msg_ready=0 for exactly 65 cycles per block; block_cnt=2.
REQ-028 Scenario abort:
- Stimulus: cfg_abort after 7 words, then 16 new words.
- Response: no done for the first burst; the new block's idx 0 core_w equals the first new word; block_cnt increments by 1 only.
REQ-029 Scenario init during ROUND:
- Stimulus: cfg_init at idx 30.
- Response: no core_init until the cycle after done; block_cnt=0 after that core_init.
REQ-030 Scenario reset mid-ROUND:
- Stimulus: areset asserted at idx 40.
- Response: all outputs go to 0 immediately; no core_update; after release, a fresh 16-word block completes normally.
REQ-031 Scenario wrap:
- Stimulus: BLOCK_CNT_W=2, five blocks.
- Response: block_cnt goes 1,2,3,0,1.
